spi_ram_ctrl: RTL

Command sequencer between the SPI slave's parallel side (rx_data/rx_valid, tx_data/tx_valid) and a single-port synchronous RAM. Decodes each 10-bit received frame: bits [9:8] are the command, bits [7:0] are the payload. Holds separate write and read address pointers and issues RAM write/read strobes. Returns read data to the SPI slave for shifting out on MISO.

---
 rtl/spi_ram_pkg.sv | 22 ++
 rtl/spi_ram_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command sequencer: frame layout,
// command codes and controller state encoding.
package spi_ram_pkg;

    localparam int FRAME_W = 10;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI frames into RAM writes/reads with separate write and
// read pointers; read data is returned to the SPI slave as a tx pulse.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FRAME_W-1:0]    rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = 3;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  rd_ptr_vld_q, rd_ptr_vld_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    cmd_e       cmd;
    logic [7:0] payload;

    assign cmd     = cmd_e'(rx_data[9:8]);
    assign payload = rx_data[7:0];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_ptr_vld_d = rd_ptr_vld_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        tx_valid_d   = 1'b0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        err_d        = 1'b0;

        // Strobes are launched together with the state change so that they
        // are high during the WRITE / RD_REQ cycle itself.
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (cmd)
                        CMD_WR_ADDR: wr_ptr_d = ADDR_WIDTH'(payload);
                        CMD_WR_DATA: begin
                            state_d     = WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = wr_ptr_q;
                            mem_wdata_d = DATA_WIDTH'(payload);
                        end
                        CMD_RD_ADDR: begin
                            rd_ptr_d     = ADDR_WIDTH'(payload);
                            rd_ptr_vld_d = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (rd_ptr_vld_q) begin
                                state_d    = RD_REQ;
                                mem_re_d   = 1'b1;
                                mem_addr_d = rd_ptr_q;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            WRITE: begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                state_d  = IDLE;
            end
            RD_REQ: begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                cnt_d    = CNT_W'(RD_LATENCY);
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                // The count reaches zero on this edge, when mem_rdata is valid.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    tx_data_d  = 8'(mem_rdata);
                    tx_valid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rx_valid && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_ptr_vld_q <= 1'b0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_ptr_vld_q <= rd_ptr_vld_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
